// File: rtl/fifo_serializer_pkg.sv
// Shared definitions for the FIFO read serializer: beat index sizing and
// the logical state encoding.
package fifo_serializer_pkg;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } ser_state_e;

   function automatic int beat_index_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/fifo_read_serializer.sv
// Pops wide words from a show-ahead FIFO and emits each as `ratio` narrow
// beats on a valid/ready stream, with no bubble between consecutive words.
module fifo_read_serializer
   import fifo_serializer_pkg::*;
#(
   parameter int out_width = 8,
   parameter int ratio     = 4,
   parameter bit msb_first = 1'b1,
   localparam int in_width = out_width * ratio,
   localparam int beat_w   = beat_index_width(ratio)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [in_width-1:0]  fifo_read_data,
   output logic                 fifo_pop,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [out_width-1:0] out_data,
   output logic                 out_last,
   output logic [beat_w-1:0]    out_beat
);

   localparam logic [beat_w-1:0] last_beat = beat_w'(ratio - 1);

   // Held word viewed as an array of beats; index 0 is the least significant slice.
   logic [ratio-1:0][out_width-1:0] word_r;
   logic [beat_w-1:0]               beat_r;
   logic                            valid_r;

   logic              hs_s;
   logic              last_s;
   logic [beat_w-1:0] sel_s;

   assign hs_s   = valid_r & out_ready;
   assign last_s = (beat_r == last_beat);

   // A new word is taken when idle or on the final handshake, never from an empty FIFO.
   assign fifo_pop = rst & ~fifo_empty & (~valid_r | (hs_s & last_s));

   // Word/beat/valid state update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         word_r  <= '0;
         beat_r  <= '0;
         valid_r <= 1'b0;
      end else if (fifo_pop) begin
         word_r  <= fifo_read_data;
         beat_r  <= '0;
         valid_r <= 1'b1;
      end else if (hs_s) begin
         if (last_s) begin
            beat_r  <= '0;
            valid_r <= 1'b0;
         end else begin
            beat_r  <= beat_r + beat_w'(1);
            valid_r <= 1'b1;
         end
      end else begin
         beat_r  <= beat_r;
         valid_r <= valid_r;
      end
   end

   // Beat slice selection according to the configured beat order.
   always_comb begin
      if (msb_first) begin
         sel_s = last_beat - beat_r;
      end else begin
         sel_s = beat_r;
      end
      out_data = word_r[sel_s];
   end

   assign out_valid = valid_r;
   assign out_beat  = beat_r;
   assign out_last  = valid_r & last_s;

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Directed bench for fifo_read_serializer (out_width 8, ratio 4, msb_first 1);
// the upstream FIFO head/empty flag is driven cycle by cycle.
module tb_fifo_read_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic [31:0] fifo_read_data;
   logic        fifo_pop;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_beat;

   int n_assert = 0;
   int n_fail   = 0;

   fifo_read_serializer #(
      .out_width(8),
      .ratio(4),
      .msb_first(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_empty(fifo_empty),
      .fifo_read_data(fifo_read_data),
      .fifo_pop(fifo_pop),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last),
      .out_beat(out_beat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the current cycle (inputs already applied), then advance one clock.
   task automatic cyc(input string tag, input logic pe, input logic ve, input logic cd,
                      input logic [7:0] de, input logic [1:0] be, input logic le);
      #1;
      chk({tag, ".pop"},   {31'd0, fifo_pop},  {31'd0, pe});
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ve});
      chk({tag, ".beat"},  {30'd0, out_beat},  {30'd0, be});
      chk({tag, ".last"},  {31'd0, out_last},  {31'd0, le});
      if (cd) begin
         chk({tag, ".data"}, {24'd0, out_data}, {24'd0, de});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1: reset with a non-empty FIFO must not pop
      rst = 1'b0; fifo_empty = 1'b0; fifo_read_data = 32'hDEADBEEF; out_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc("t1.rst0", 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
      cyc("t1.rst1", 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
      cyc("t1.rst2", 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
      rst = 1'b1;
      cyc("t1.rel",  1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
      fifo_empty = 1'b1;
      cyc("t1.b0", 1'b0, 1'b1, 1'b1, 8'hDE, 2'd0, 1'b0);
      cyc("t1.b1", 1'b0, 1'b1, 1'b1, 8'hAD, 2'd1, 1'b0);
      cyc("t1.b2", 1'b0, 1'b1, 1'b1, 8'hBE, 2'd2, 1'b0);
      cyc("t1.b3", 1'b0, 1'b1, 1'b1, 8'hEF, 2'd3, 1'b1);
      cyc("t1.idle", 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);

      // 2: single word; data changed while empty must be ignored
      fifo_empty = 1'b0; fifo_read_data = 32'hA1B2C3D4;
      cyc("t2.pop", 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      fifo_empty = 1'b1; fifo_read_data = 32'hFFFFFFFF;
      cyc("t2.b0", 1'b0, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b0);
      cyc("t2.b1", 1'b0, 1'b1, 1'b1, 8'hB2, 2'd1, 1'b0);
      cyc("t2.b2", 1'b0, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b0);
      cyc("t2.b3", 1'b0, 1'b1, 1'b1, 8'hD4, 2'd3, 1'b1);
      cyc("t2.idle", 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);

      // 3: two queued words, back to back
      fifo_empty = 1'b0; fifo_read_data = 32'h11223344;
      cyc("t3.pop0", 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      fifo_read_data = 32'h55667788;
      cyc("t3.b0", 1'b0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b0);
      cyc("t3.b1", 1'b0, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0);
      cyc("t3.b2", 1'b0, 1'b1, 1'b1, 8'h33, 2'd2, 1'b0);
      cyc("t3.b3", 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1);
      fifo_empty = 1'b1;
      cyc("t3.b4", 1'b0, 1'b1, 1'b1, 8'h55, 2'd0, 1'b0);
      cyc("t3.b5", 1'b0, 1'b1, 1'b1, 8'h66, 2'd1, 1'b0);
      cyc("t3.b6", 1'b0, 1'b1, 1'b1, 8'h77, 2'd2, 1'b0);
      cyc("t3.b7", 1'b0, 1'b1, 1'b1, 8'h88, 2'd3, 1'b1);
      cyc("t3.idle", 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);

      // 4: backpressure at beat 2 with the next word already waiting
      fifo_empty = 1'b0; fifo_read_data = 32'hA1B2C3D4;
      cyc("t4.pop", 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      fifo_read_data = 32'h0F0E0D0C;
      cyc("t4.b0", 1'b0, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b0);
      cyc("t4.b1", 1'b0, 1'b1, 1'b1, 8'hB2, 2'd1, 1'b0);
      out_ready = 1'b0;
      cyc("t4.st0", 1'b0, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b0);
      cyc("t4.st1", 1'b0, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b0);
      cyc("t4.st2", 1'b0, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b0);
      out_ready = 1'b1;
      cyc("t4.b2", 1'b0, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b0);
      cyc("t4.b3", 1'b1, 1'b1, 1'b1, 8'hD4, 2'd3, 1'b1);

      // 5: FIFO empty on the last handshake, then a late word
      fifo_empty = 1'b1;
      cyc("t5.b0", 1'b0, 1'b1, 1'b1, 8'h0F, 2'd0, 1'b0);
      cyc("t5.b1", 1'b0, 1'b1, 1'b1, 8'h0E, 2'd1, 1'b0);
      cyc("t5.b2", 1'b0, 1'b1, 1'b1, 8'h0D, 2'd2, 1'b0);
      cyc("t5.b3", 1'b0, 1'b1, 1'b1, 8'h0C, 2'd3, 1'b1);
      cyc("t5.gap0", 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      cyc("t5.gap1", 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      fifo_empty = 1'b0; fifo_read_data = 32'h5A6B7C8D;
      cyc("t5.pop", 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      fifo_empty = 1'b1;
      cyc("t5.c0", 1'b0, 1'b1, 1'b1, 8'h5A, 2'd0, 1'b0);
      cyc("t5.c1", 1'b0, 1'b1, 1'b1, 8'h6B, 2'd1, 1'b0);
      cyc("t5.c2", 1'b0, 1'b1, 1'b1, 8'h7C, 2'd2, 1'b0);
      cyc("t5.c3", 1'b0, 1'b1, 1'b1, 8'h8D, 2'd3, 1'b1);
      cyc("t5.idle", 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);

      // 6: reset mid-word discards it; next word starts at beat 0
      fifo_empty = 1'b0; fifo_read_data = 32'hCAFEF00D;
      cyc("t6.pop", 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      fifo_read_data = 32'h01020304;
      cyc("t6.b0", 1'b0, 1'b1, 1'b1, 8'hCA, 2'd0, 1'b0);
      rst = 1'b0;
      cyc("t6.rstb1", 1'b0, 1'b1, 1'b1, 8'hFE, 2'd1, 1'b0);
      cyc("t6.rsth",  1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
      rst = 1'b1;
      cyc("t6.rel", 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
      fifo_empty = 1'b1;
      cyc("t6.n0", 1'b0, 1'b1, 1'b1, 8'h01, 2'd0, 1'b0);
      cyc("t6.n1", 1'b0, 1'b1, 1'b1, 8'h02, 2'd1, 1'b0);
      cyc("t6.n2", 1'b0, 1'b1, 1'b1, 8'h03, 2'd2, 1'b0);
      cyc("t6.n3", 1'b0, 1'b1, 1'b1, 8'h04, 2'd3, 1'b1);
      cyc("t6.idle", 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
